// File: rtl/pair_vote_ctrl.sv
// Round-robin vote collector for a 3-input 2-of-3 majority detector.
// Captures one vote per cycle, closes the round when all slots fill or the timer expires.
module pair_vote_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [2:0]       vote,
    output logic [2:0]       gnt,
    output logic             result_val,
    input  logic             result_rdy,
    output logic             result,
    output logic [2:0]       result_mask,
    output logic             result_timeout,
    output logic [CNT_W-1:0] round_cnt
);

    typedef enum logic {COLLECT, RESULT} state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic [2:0] slot_q;
    logic [2:0] filled_q;
    logic [1:0] ptr_q;
    logic [7:0] timer_q;
    logic       run_q;

    logic [2:0] elig;
    logic [2:0] gnt_c;
    logic [2:0] slot_d;
    logic [2:0] filled_d;
    logic [1:0] ptr_d;
    logic       grant;
    logic       third_fill;
    logic       tmo_hit;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | ((s[0] | s[1]) & s[2]);
    endfunction

    // Round-robin search begins at the pointer; filled slots are never eligible.
    always_comb begin
        elig  = req & ~filled_q;
        gnt_c = 3'b000;
        if (state_q == COLLECT) begin
            unique case (ptr_q)
                2'd1: begin
                    if (elig[1])      gnt_c = 3'b010;
                    else if (elig[2]) gnt_c = 3'b100;
                    else if (elig[0]) gnt_c = 3'b001;
                end
                2'd2: begin
                    if (elig[2])      gnt_c = 3'b100;
                    else if (elig[0]) gnt_c = 3'b001;
                    else if (elig[1]) gnt_c = 3'b010;
                end
                default: begin
                    if (elig[0])      gnt_c = 3'b001;
                    else if (elig[1]) gnt_c = 3'b010;
                    else if (elig[2]) gnt_c = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_c[0]) ptr_d = 2'd1;
        if (gnt_c[1]) ptr_d = 2'd2;
        if (gnt_c[2]) ptr_d = 2'd0;
        slot_d     = slot_q | (gnt_c & vote);
        filled_d   = filled_q | gnt_c;
        grant      = |gnt_c;
        third_fill = grant && (filled_d == 3'b111);
        tmo_hit    = run_q && (timer_q == TMAX);
    end

    // Grant is forced low while reset is held so nothing is offered during reset.
    assign gnt = rst_n ? gnt_c : 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= COLLECT;
            slot_q         <= 3'b000;
            filled_q       <= 3'b000;
            ptr_q          <= 2'd0;
            timer_q        <= 8'd0;
            run_q          <= 1'b0;
            round_cnt      <= '0;
            result_val     <= 1'b0;
            result         <= 1'b0;
            result_mask    <= 3'b000;
            result_timeout <= 1'b0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    slot_q   <= slot_d;
                    filled_q <= filled_d;
                    ptr_q    <= ptr_d;
                    if (grant && !run_q) begin
                        timer_q <= 8'd0;
                        run_q   <= 1'b1;
                    end else if (run_q) begin
                        timer_q <= timer_q + 8'd1;
                    end
                    // A completing vote beats a coincident timeout.
                    if (third_fill || tmo_hit) begin
                        state_q        <= RESULT;
                        result_val     <= 1'b1;
                        result         <= maj3(slot_d);
                        result_mask    <= filled_d;
                        result_timeout <= !third_fill;
                    end
                end
                RESULT: begin
                    if (result_rdy) begin
                        state_q     <= COLLECT;
                        result_val  <= 1'b0;
                        slot_q      <= 3'b000;
                        filled_q    <= 3'b000;
                        timer_q     <= 8'd0;
                        run_q       <= 1'b0;
                        round_cnt   <= round_cnt + 1'b1;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_pair_vote_ctrl.sv
// Bench for pair_vote_ctrl: a default-parameter instance driven from a vector table,
// and a TIMEOUT=4 / CNT_W=2 instance exercised with hand-written sequences.
module tb_pair_vote_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0] req_a, vote_a, gnt_a, mask_a;
    logic       rdy_a, val_a, res_a, to_a;
    logic [7:0] cnt_a;

    logic [2:0] req_b, vote_b, gnt_b, mask_b;
    logic       rdy_b, val_b, res_b, to_b;
    logic [1:0] cnt_b;

    pair_vote_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req_a), .vote(vote_a), .gnt(gnt_a),
        .result_val(val_a), .result_rdy(rdy_a), .result(res_a),
        .result_mask(mask_a), .result_timeout(to_a), .round_cnt(cnt_a)
    );

    pair_vote_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut_t (
        .clk(clk), .rst_n(rst_n), .req(req_b), .vote(vote_b), .gnt(gnt_b),
        .result_val(val_b), .result_rdy(rdy_b), .result(res_b),
        .result_mask(mask_b), .result_timeout(to_b), .round_cnt(cnt_b)
    );

    typedef struct {
        logic [2:0] req;
        logic [2:0] vote;
        logic       rdy;
        logic [2:0] gnt;
        logic       val;
        logic       res;
        logic [2:0] mask;
        logic       to;
        logic [7:0] cnt;
    } vec_t;

    vec_t vq[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic add(input logic [2:0] rq, input logic [2:0] vt, input logic rd,
                       input logic [2:0] g, input logic v, input logic r,
                       input logic [2:0] m, input logic t, input logic [7:0] c);
        vec_t e;
        e.req = rq; e.vote = vt; e.rdy = rd; e.gnt = g; e.val = v;
        e.res = r; e.mask = m; e.to = t; e.cnt = c;
        vq.push_back(e);
    endtask

    task automatic cyc_a(input logic [2:0] rq, input logic [2:0] vt, input logic rd);
        @(negedge clk);
        req_a = rq; vote_a = vt; rdy_a = rd;
        #1;
    endtask

    task automatic cyc_b(input logic [2:0] rq, input logic [2:0] vt, input logic rd);
        @(negedge clk);
        req_b = rq; vote_b = vt; rdy_b = rd;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = '0; vote_a = '0; rdy_a = 1'b0;
        req_b = '0; vote_b = '0; rdy_b = 1'b0;

        // Full round, result held under backpressure, repeated-request voter.
        add(3'b111, 3'b110, 0, 3'b001, 0, 0, 3'b000, 0, 8'd0);
        add(3'b111, 3'b110, 0, 3'b010, 0, 0, 3'b000, 0, 8'd0);
        add(3'b111, 3'b110, 0, 3'b100, 0, 0, 3'b000, 0, 8'd0);
        add(3'b111, 3'b110, 1, 3'b000, 1, 1, 3'b111, 0, 8'd0);
        add(3'b111, 3'b100, 0, 3'b001, 0, 0, 3'b000, 0, 8'd1);
        add(3'b111, 3'b100, 0, 3'b010, 0, 0, 3'b000, 0, 8'd1);
        add(3'b111, 3'b100, 0, 3'b100, 0, 0, 3'b000, 0, 8'd1);
        for (int i = 0; i < 5; i++)
            add(3'b111, 3'b100, 0, 3'b000, 1, 0, 3'b111, 0, 8'd1);
        add(3'b111, 3'b100, 1, 3'b000, 1, 0, 3'b111, 0, 8'd1);
        add(3'b000, 3'b000, 0, 3'b000, 0, 0, 3'b000, 0, 8'd2);
        add(3'b010, 3'b010, 0, 3'b010, 0, 0, 3'b000, 0, 8'd2);
        add(3'b010, 3'b000, 0, 3'b000, 0, 0, 3'b000, 0, 8'd2);
        add(3'b010, 3'b010, 0, 3'b000, 0, 0, 3'b000, 0, 8'd2);
        add(3'b010, 3'b000, 0, 3'b000, 0, 0, 3'b000, 0, 8'd2);
        add(3'b011, 3'b000, 0, 3'b001, 0, 0, 3'b000, 0, 8'd2);
        add(3'b111, 3'b100, 0, 3'b100, 0, 0, 3'b000, 0, 8'd2);
        add(3'b000, 3'b000, 1, 3'b000, 1, 1, 3'b111, 0, 8'd2);
        add(3'b000, 3'b000, 0, 3'b000, 0, 0, 3'b000, 0, 8'd3);

        repeat (2) @(negedge clk);
        #1;
        chk("rst.val", val_a, 0);
        chk("rst.gnt", gnt_a, 0);
        chk("rst.cnt", cnt_a, 0);
        chk("rst.mask", mask_a, 0);
        chk("rst.res", res_a, 0);
        chk("rst.to", to_a, 0);
        chk("rst_t.val", val_b, 0);
        chk("rst_t.cnt", cnt_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            cyc_a(vq[i].req, vq[i].vote, vq[i].rdy);
            chk($sformatf("v%0d.gnt", i), gnt_a, vq[i].gnt);
            chk($sformatf("v%0d.val", i), val_a, vq[i].val);
            chk($sformatf("v%0d.cnt", i), cnt_a, vq[i].cnt);
            if (vq[i].val) begin
                chk($sformatf("v%0d.res", i), res_a, vq[i].res);
                chk($sformatf("v%0d.mask", i), mask_a, vq[i].mask);
                chk($sformatf("v%0d.to", i), to_a, vq[i].to);
            end
        end

        // Timeout round with only voter 2.
        cyc_b(3'b100, 3'b100, 0);
        chk("tmo.gnt", gnt_b, 3'b100);
        for (int k = 0; k < 4; k++) begin
            cyc_b(3'b000, 3'b000, 0);
            chk($sformatf("tmo.wait%0d", k), val_b, 0);
        end
        cyc_b(3'b000, 3'b000, 1);
        chk("tmo.val", val_b, 1);
        chk("tmo.res", res_b, 0);
        chk("tmo.mask", mask_b, 3'b100);
        chk("tmo.to", to_b, 1);
        cyc_b(3'b000, 3'b000, 0);
        chk("tmo.cnt", cnt_b, 1);
        chk("tmo.valclr", val_b, 0);

        // Last vote lands on the same cycle the timer expires.
        cyc_b(3'b001, 3'b001, 0);
        chk("coin.g0", gnt_b, 3'b001);
        cyc_b(3'b010, 3'b010, 0);
        chk("coin.g1", gnt_b, 3'b010);
        cyc_b(3'b000, 3'b000, 0);
        cyc_b(3'b000, 3'b000, 0);
        chk("coin.idle", val_b, 0);
        cyc_b(3'b100, 3'b100, 0);
        chk("coin.g2", gnt_b, 3'b100);
        chk("coin.pre", val_b, 0);
        cyc_b(3'b000, 3'b000, 1);
        chk("coin.val", val_b, 1);
        chk("coin.to", to_b, 0);
        chk("coin.mask", mask_b, 3'b111);
        chk("coin.res", res_b, 1);
        cyc_b(3'b000, 3'b000, 0);
        chk("coin.cnt", cnt_b, 2);

        // Reset in the middle of a round with two slots filled.
        cyc_a(3'b111, 3'b011, 0);
        chk("mid.g0", gnt_a, 3'b001);
        cyc_a(3'b111, 3'b011, 0);
        chk("mid.g1", gnt_a, 3'b010);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid.val", val_a, 0);
        chk("mid.cnt", cnt_a, 0);
        chk("mid.gnt", gnt_a, 0);
        chk("mid.cnt_t", cnt_b, 0);
        @(negedge clk);
        rst_n = 1'b1; req_a = 3'b111; vote_a = 3'b111; rdy_a = 1'b0;
        #1;
        chk("post.g0", gnt_a, 3'b001);
        cyc_a(3'b111, 3'b111, 0);
        chk("post.g1", gnt_a, 3'b010);
        chk("post.v1", val_a, 0);
        cyc_a(3'b111, 3'b111, 0);
        chk("post.g2", gnt_a, 3'b100);
        chk("post.v2", val_a, 0);
        cyc_a(3'b000, 3'b000, 1);
        chk("post.val", val_a, 1);
        chk("post.res", res_a, 1);
        chk("post.mask", mask_a, 3'b111);
        cyc_a(3'b000, 3'b000, 0);
        chk("post.cnt", cnt_a, 1);

        // Two-bit round counter wraps.
        for (int r = 0; r < 5; r++) begin
            for (int s = 0; s < 3; s++) cyc_b(3'b111, 3'b000, 0);
            cyc_b(3'b000, 3'b000, 1);
            chk($sformatf("wrap%0d.val", r), val_b, 1);
            cyc_b(3'b000, 3'b000, 0);
            chk($sformatf("wrap%0d.cnt", r), cnt_b, (r + 1) % 4);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
